// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte-stream input and instruction-memory write/status bundle for the boot loader.
interface imem_boot_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  modport master (output in_valid, in_data, input in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err);
  modport slave  (input in_valid, in_data, output in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err);
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a counted big-endian byte stream into IM words and holds the core until the load completes.
module imem_boot_loader #(parameter int ADDR_W = 10) (
  input logic             clk,
  input logic             rst_n,
  imem_boot_loader_if.slave bus
);
  localparam logic [2:0] S_HDR0  = 3'd0;
  localparam logic [2:0] S_HDR1  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;
  localparam logic [16:0] DEPTH  = 17'd1 << ADDR_W;
  logic [2:0]        r_state, w_next;
  logic              r_ready;
  logic [7:0]        r_hi;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_bcnt;
  logic [31:0]       r_asm;
  logic              w_xfer;
  logic [15:0]       w_hdr_n;
  logic [ADDR_W:0]   w_addr_p1;
  logic              w_last;
  assign w_xfer    = bus.in_valid & r_ready;
  assign w_hdr_n   = {r_hi, bus.in_data};
  assign w_addr_p1 = {1'b0, r_addr} + (ADDR_W+1)'(1);
  assign w_last    = w_addr_p1 == r_n;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0:  w_next = w_xfer ? S_HDR1 : S_HDR0;
      S_HDR1:  w_next = !w_xfer ? S_HDR1 :
                        (w_hdr_n == 16'd0) ? S_DONE :
                        ({1'b0, w_hdr_n} > DEPTH) ? S_ERR : S_DATA;
      S_DATA:  w_next = (w_xfer && r_bcnt == 2'd3) ? S_WRITE : S_DATA;
      S_WRITE: w_next = w_last ? S_DONE : S_DATA;
      default: w_next = r_state;
    endcase
  end
  // in_ready is registered from the next state, so it never depends combinationally on in_valid
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_HDR0;
      r_ready <= 1'b0;
      r_hi    <= 8'd0;
      r_n     <= '0;
      r_addr  <= '0;
      r_bcnt  <= 2'd0;
      r_asm   <= 32'd0;
    end else begin
      r_state <= w_next;
      r_ready <= (w_next == S_HDR0) || (w_next == S_HDR1) || (w_next == S_DATA);
      if (w_xfer && r_state == S_HDR0) r_hi <= bus.in_data;
      if (w_xfer && r_state == S_HDR1) begin
        r_n    <= w_hdr_n[ADDR_W:0];
        r_addr <= '0;
        r_bcnt <= 2'd0;
      end
      if (w_xfer && r_state == S_DATA) begin
        r_asm  <= {r_asm[23:0], bus.in_data};
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (r_state == S_WRITE && !w_last) r_addr <= r_addr + ADDR_W'(1);
    end
  assign bus.in_ready = r_ready;
  assign bus.im_we    = r_state == S_WRITE;
  assign bus.im_addr  = r_addr;
  assign bus.im_wdata = r_asm;
  assign bus.cpu_hold = r_state != S_DONE;
  assign bus.done     = r_state == S_DONE;
  assign bus.err      = r_state == S_ERR;
endmodule
